// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encodings and
// counter sizing.
package seq_divider_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter must hold SIZE itself, hence clog2(SIZE+1).
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/seq_divider_yadder.sv
// Plain ripple-carry adder, one full-adder cell per bit.
module yAdder #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] z
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign z[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock; DIVU/REMU unit with
// RISC-V divide-by-zero results (Q = all ones, R = dividend).
module seq_divider
  import seq_divider_defs::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  output logic [SIZE-1:0] Q,
  output logic [SIZE-1:0] R,
  output logic            busy,
  output logic            done,
  output logic            div0
);

  localparam int CW = cnt_width(SIZE);

  state_t          state;
  logic [SIZE-1:0] breg;
  logic [CW-1:0]   cnt;
  logic [SIZE:0]   rem_sh;
  logic [SIZE:0]   diff;

  // The bit shifted out of P stays in the trial value, so divisors with the
  // MSB set still see the full 2P+q partial remainder.
  assign rem_sh = {R, Q[SIZE-1]};

  yAdder #(.W(SIZE + 1)) u_sub (
    .a   (rem_sh),
    .b   (~{1'b0, breg}),
    .cin (1'b1),
    .z   (diff)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      Q     <= '0;
      R     <= '0;
      breg  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            if (B != '0) begin
              Q     <= A;
              R     <= '0;
              breg  <= B;
              cnt   <= CW'(SIZE);
              div0  <= 1'b0;
              busy  <= 1'b1;
              state <= S_RUN;
            end else begin
              Q     <= '1;
              R     <= A;
              div0  <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          // diff MSB set means the trial subtraction went negative: restore.
          Q   <= {Q[SIZE-2:0], ~diff[SIZE]};
          R   <= diff[SIZE] ? rem_sh[SIZE-1:0] : diff[SIZE-1:0];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench: SIZE=4 directed cases and a SIZE=32 random sweep.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start4, busy4, done4, div04;
  logic [3:0]  a4, b4, q4, r4;
  logic        start32, busy32, done32, div032;
  logic [31:0] a32, b32, q32, r32;

  seq_divider #(.SIZE(4)) u_div4 (
    .clk(clk), .reset(reset), .start(start4), .A(a4), .B(b4),
    .Q(q4), .R(r4), .busy(busy4), .done(done4), .div0(div04)
  );

  seq_divider #(.SIZE(32)) u_div32 (
    .clk(clk), .reset(reset), .start(start32), .A(a32), .B(b32),
    .Q(q32), .R(r32), .busy(busy32), .done(done32), .div0(div032)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        d0;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t sb4[$];
  exp_t sb32[$];
  exp_t e4, e32;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done4) begin
      if (sb4.size() == 0) chk("done4_unexpected", 64'(done4), 64'd0);
      else begin
        e4 = sb4.pop_front();
        chk("q4", 64'(q4), 64'(e4.q));
        chk("r4", 64'(r4), 64'(e4.r));
        chk("div0_4", 64'(div04), 64'(e4.d0));
        chk("lat4", 64'(cyc - e4.cyc), 64'(e4.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (done32) begin
      if (sb32.size() == 0) chk("done32_unexpected", 64'(done32), 64'd0);
      else begin
        e32 = sb32.pop_front();
        chk("q32", 64'(q32), 64'(e32.q));
        chk("r32", 64'(r32), 64'(e32.r));
        chk("div0_32", 64'(div032), 64'(e32.d0));
        chk("lat32", 64'(cyc - e32.cyc), 64'(e32.lat));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; start is held for exactly one cycle.
  task automatic go4(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    start4 = 1'b1; a4 = a; b4 = b;
    e.q   = (b == 0) ? 32'hF : 32'(a / b);
    e.r   = (b == 0) ? 32'(a) : 32'(a % b);
    e.d0  = (b == 0);
    e.cyc = cyc;
    e.lat = (b == 0) ? 1 : 5;
    sb4.push_back(e);
    tick(1);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
  endtask

  task automatic go32(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start32 = 1'b1; a32 = a; b32 = b;
    e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.d0  = (b == 0);
    e.cyc = cyc;
    e.lat = (b == 0) ? 1 : 33;
    sb32.push_back(e);
    tick(1);
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
  endtask

  task automatic drain4();
    for (int i = 0; i < 40 && sb4.size() != 0; i++) tick(1);
    chk("drain4", 64'(sb4.size()), 64'd0);
    tick(1);
  endtask

  task automatic drain32();
    for (int i = 0; i < 60 && sb32.size() != 0; i++) tick(1);
    chk("drain32", 64'(sb32.size()), 64'd0);
    tick(1);
  endtask

  initial begin
    int c;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start32 = 1'b0; a32 = '0; b32 = '0;
    tick(2);
    reset = 1'b0;
    chk("rst_q", 64'(q4), 64'd0);
    chk("rst_r", 64'(r4), 64'd0);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_done", 64'(done4), 64'd0);
    chk("rst_div0", 64'(div04), 64'd0);

    // 13/3: busy through cycles 1..4, done in cycle 5
    c = cyc;
    go4(4'd13, 4'd3);
    for (int k = 1; k <= 4; k++) begin
      chk("busy_run", 64'(busy4), 64'd1);
      tick(1);
    end
    chk("busy_end", 64'(busy4), 64'd0);
    drain4();

    go4(4'd2, 4'd7);   drain4();
    go4(4'd15, 4'd1);  drain4();
    go4(4'd15, 4'd15); drain4();

    go4(4'd9, 4'd0);
    chk("div0_busy", 64'(busy4), 64'd0);
    drain4();

    // start while busy is dropped; start in the DONE cycle is taken
    c = cyc;
    go4(4'd13, 4'd3);
    tick(1);
    start4 = 1'b1; a4 = 4'd6; b4 = 4'd2;
    tick(1);
    start4 = 1'b0;
    while (cyc < c + 5) tick(1);
    chk("b2b_in_done", 64'(done4), 64'd1);
    go4(4'd6, 4'd2);
    drain4();

    // reset mid-run discards the operation
    go4(4'd14, 4'd4);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sb4.delete();
    chk("abort_q", 64'(q4), 64'd0);
    chk("abort_r", 64'(r4), 64'd0);
    chk("abort_busy", 64'(busy4), 64'd0);
    chk("abort_done", 64'(done4), 64'd0);
    chk("abort_div0", 64'(div04), 64'd0);
    tick(3);
    go4(4'd14, 4'd4);
    drain4();

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      case (i % 10)
        0: rb = '0;
        1: ra = 32'hFFFF_FFFF;
        2: begin ra = ra >> 20; rb = rb | 32'h8000_0000; end
        3: ra = '0;
        default: ;
      endcase
      go32(ra, rb);
      drain32();
    end

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
